// File: rtl/sram_rd_sched.sv
// Round-robin scheduler sharing one SRAM read port among NUM_PORTS burst readers; gnt and first address one cycle after req, data RD_LATENCY later.
// No downstream backpressure; optional SRAM_RD_STALL_EN adds rd_stall, which pauses issue and blocks new grants.
module sram_rd_sched #(
  parameter int NUM_PORTS  = 16,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [ADDR_WIDTH*NUM_PORTS-1:0] req_addr,
  input  logic [LEN_WIDTH*NUM_PORTS-1:0]  req_len,
  output logic [NUM_PORTS-1:0]            gnt,
  output logic                            busy,
  output logic                            sram_enb,
  output logic [ADDR_WIDTH-1:0]           sram_addrb,
  input  logic [DATA_WIDTH-1:0]           sram_doutb,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic [NUM_PORTS-1:0]            rd_vld,
  output logic [NUM_PORTS-1:0]            rd_last
`ifdef SRAM_RD_STALL_EN
  ,
  input  logic                            rd_stall
`endif
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  typedef struct packed {
    logic          vld;
    logic          last;
    logic [PW-1:0] owner;
  } tag_t;

  state_t                     state_q, state_d;
  logic [PW-1:0]              ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]      addr_cnt_q, addr_cnt_d;
  logic [LEN_WIDTH-1:0]       remaining_q, remaining_d;
  logic [PW-1:0]              owner_q, owner_d;
  logic [NUM_PORTS-1:0]       gnt_q, gnt_d;
  tag_t [RD_LATENCY-1:0]      tag_q, tag_d;

  logic                       stall;
  logic                       issuing;
  logic                       final_beat;
  logic                       arb_en;
  logic [NUM_PORTS-1:0]       eligible;
  logic [ADDR_WIDTH-1:0]      port_addr [NUM_PORTS];
  logic [LEN_WIDTH-1:0]       port_len  [NUM_PORTS];
  logic                       win_vld;
  logic [PW-1:0]              win_idx;
  int                         idx;

`ifdef SRAM_RD_STALL_EN
  assign stall = rd_stall;
`else
  assign stall = 1'b0;
`endif

  assign issuing    = (state_q == ISSUE) && !stall;
  assign final_beat = issuing && (remaining_q == LEN_WIDTH'(1));
  assign arb_en     = ((state_q == IDLE) && !stall) || final_beat;

  // Owner is masked while it still holds req during its own final beat.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_addr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      port_len[i]  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      eligible[i]  = req[i] && (port_len[i] != '0);
    end
    if (state_q == ISSUE) begin
      eligible[owner_q] = 1'b0;
    end
  end

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(ptr_q) + k) % NUM_PORTS;
      if (!win_vld && eligible[PW'(idx)]) begin
        win_vld = 1'b1;
        win_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    addr_cnt_d  = addr_cnt_q;
    remaining_d = remaining_q;
    owner_d     = owner_q;
    gnt_d       = '0;

    if (issuing) begin
      addr_cnt_d  = addr_cnt_q + ADDR_WIDTH'(1);
      remaining_d = remaining_q - LEN_WIDTH'(1);
      if (final_beat) begin
        state_d = IDLE;
      end
    end

    if (arb_en && win_vld) begin
      gnt_d[win_idx] = 1'b1;
      ptr_d          = win_idx;
      addr_cnt_d     = port_addr[win_idx];
      remaining_d    = port_len[win_idx];
      owner_d        = win_idx;
      state_d        = ISSUE;
    end
  end

  // Stalled cycles push a null tag so returning data stays aligned with the SRAM pipe.
  always_comb begin
    tag_d          = '0;
    for (int k = RD_LATENCY - 1; k > 0; k--) begin
      tag_d[k] = tag_q[k-1];
    end
    tag_d[0].vld   = issuing;
    tag_d[0].last  = final_beat;
    tag_d[0].owner = owner_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= PW'(NUM_PORTS - 1);
      addr_cnt_q  <= '0;
      remaining_q <= '0;
      owner_q     <= '0;
      gnt_q       <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      addr_cnt_q  <= addr_cnt_d;
      remaining_q <= remaining_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      tag_q       <= tag_d;
    end
  end

  always_comb begin
    rd_vld  = '0;
    rd_last = '0;
    rd_vld[tag_q[RD_LATENCY-1].owner]  = tag_q[RD_LATENCY-1].vld;
    rd_last[tag_q[RD_LATENCY-1].owner] = tag_q[RD_LATENCY-1].vld && tag_q[RD_LATENCY-1].last;
  end

  assign gnt        = gnt_q;
  assign busy       = (state_q == ISSUE);
  assign sram_enb   = issuing;
  assign sram_addrb = busy ? addr_cnt_q : '0;
  assign rd_data    = sram_doutb;

endmodule
